fft_out_serializer: RTL
=======================

# fft_out_serializer

Downstream stage of the 8-point FFT core. It captures each parallel output frame (`NUM_FFT_POINT` packets) from the core, stores it in a two-bank ping-pong buffer, and streams the bins out one per beat in natural frequency order over a valid/ready interface. The FFT core is a free-running pipeline that cannot stall, so frames arriving with no free bank are dropped and flagged.

## Interface
Parameters:
- `NUM_FFT_POINT`, 8: points per frame, taken from the shared package. Must be a power of two. Index width is `IDX_W = $clog2(NUM_FFT_POINT)`.

Ports:
- `clock`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `frame_valid`  in  1  the core's output frame is valid this cycle; driven by the core's valid delay line.
- `frame_data`  in  `FFT_OUTPUT_PACKET [NUM_FFT_POINT-1:0]`  the core's output frame, in bit-reversed bin order.
- `frame_ready`  out  1  at least one bank is empty. Registered.
- `out_valid`  out  1  `out_data` holds a valid bin.
- `out_ready`  in  1  downstream accepts the bin.
- `out_data`  out  `FFT_OUTPUT_PACKET`  current bin.
- `out_index`  out  `IDX_W`  frequency index of `out_data`, 0..NUM_FFT_POINT-1.
- `out_last`  out  1  `out_data` is the last bin of the frame.
- `overflow`  out  1  sticky; set when a frame is dropped.
- `drop_count`  out  8  count of dropped frames; saturates at 255.

## Operation
- Two banks (0 and 1), each holding `NUM_FFT_POINT` packets, with per-bank `full` flags.
- Write pointer `wr_bank` and read pointer `rd_bank` each start at bank 0.
- Capture:
  - On `frame_valid && frame_ready`, the whole frame is written into `wr_bank`.
  - That bank's `full` flag is set.
  - `wr_bank` toggles.
- Drop:
  - On `frame_valid && !frame_ready`, the frame is discarded and bank contents are untouched.
  - `overflow` is set to 1.
  - `drop_count` increments, saturating at 255.
- Read state machine:
  - States: `IDLE` and `STREAM`.
  - `IDLE` → `STREAM` when `full[rd_bank]` is set. The beat counter `k` resets to 0.
  - In `STREAM`, each `out_valid && out_ready` handshake increments `k`.
  - On the handshake where `k == NUM_FFT_POINT-1`: clear `full[rd_bank]`, toggle `rd_bank`, then go to `STREAM` if the other bank is full, otherwise to `IDLE`.
- Read order: beat `k` presents bank entry `bitrev(k)`. `out_index` is `k`. `out_last` is `(k == NUM_FFT_POINT-1)`.
- `out_data`, `out_index` and `out_last` hold stable while `out_valid && !out_ready`.
- Simultaneous capture and release:
  - When a bank frees on the same cycle another frame is offered, the offer is judged by the registered `frame_ready` only, so no combinational path exists from `out_ready` to `frame_ready`.
  - A bank freed in cycle t is writable from cycle t+1.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_index` = 0, `out_last` = 0.
  - `overflow` = 0, `drop_count` = 0.
  - `frame_ready` = 1.
  - Both `full` flags = 0, both pointers = 0, state = `IDLE`.
- Reset mid-stream abandons both banks; no partial frame is emitted after reset deasserts.
- Latency: a frame captured at edge t gives `out_valid` = 1 with bin 0 from cycle t+1.
- Throughput with `out_ready` held high: one bin per cycle, and back-to-back frames stream with no bubble.
- Sustained input: frames every `NUM_FFT_POINT` cycles with `out_ready` high never drop.
- `frame_ready` deasserts the cycle after the second bank fills. It reasserts the cycle after the last beat of the read bank handshakes.

## Configuration
- `FFT_OUT_REORDER_EN` defined: the read order is bit-reversed, so bins emerge in natural frequency order, as described above.
- `FFT_OUT_REORDER_EN` undefined: beat `k` reads bank entry `k`, so bins emerge in the core's bit-reversed order. `out_index` still reports the true frequency index, which is `bitrev(k)`.

## Structure
- Shared package holds:
  - `NUM_FFT_POINT`
  - `FFT_OUTPUT_PACKET`
  - a `bitrev` function parameterised on `IDX_W`
  - the read-state enum `FFT_SER_STATE` {`IDLE`, `STREAM`}
- One sub-module, `fft_frame_bank`: a single bank holding a parallel write port, an indexed read port and the `full` flag. It is instantiated twice.
- The top level holds the pointers, the read state machine, the beat counter and the drop logic.

## Test plan
- Single frame, reorder enabled, `out_ready` = 1:
  - Stimulus: input `frame_data[i].real` = i, which is bit-reversed order.
  - Required: 8 beats from cycle t+1 with `real` = 0,4,2,6,1,5,3,7, `out_index` = 0..7, and `out_last` on beat 7 only.
- Backpressure:
  - Stimulus: toggle `out_ready` every cycle.
  - Required: `out_data` stable while stalled, 8 beats in 16 cycles, no duplicated or skipped bins.
- Overflow:
  - Stimulus: `out_ready` = 0 and 3 frames offered.
  - Required: first two captured, `frame_ready` = 0 after the second, third dropped. Then `overflow` = 1 and `drop_count` = 1, and the streamed data matches frames 1 and 2.
- Back-to-back:
  - Stimulus: frames every 8 cycles for 10 frames with `out_ready` = 1.
  - Required: 80 contiguous beats and `drop_count` = 0.
- Reset mid-stream:
  - Stimulus: assert `reset` low on beat 3.
  - Required: next cycle `out_valid` = 0, `frame_ready` = 1 and `overflow` = 0. A new frame then streams from bin 0.
- Macro off:
  - Stimulus: same as the single-frame test with `FFT_OUT_REORDER_EN` undefined.
  - Required: `real` = 0..7 in order, and `out_index` = 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_out_serializer_pkg.sv
// Shared FFT output types: packet/frame layout, bitrev helper and serializer read-state enum.
// NUM_FFT_POINT must stay a power of two so the beat counter wraps cleanly.
package fft_out_serializer_pkg;

  localparam int NUM_FFT_POINT = 8;
  localparam int IDX_W         = $clog2(NUM_FFT_POINT);
  localparam int SAMPLE_W      = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } FFT_OUTPUT_PACKET;

  typedef FFT_OUTPUT_PACKET [NUM_FFT_POINT-1:0] fft_frame_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } FFT_SER_STATE;

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) begin
      r[i] = k[IDX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Frame-capture and bin-stream signals of the FFT output serializer.
// master = surrounding logic (core + sink), slave = the serializer.
interface fft_out_serializer_if;
  import fft_out_serializer_pkg::*;

  logic             frame_valid;
  fft_frame_t       frame_data;
  logic             frame_ready;
  logic             out_valid;
  logic             out_ready;
  FFT_OUTPUT_PACKET out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             overflow;
  logic [7:0]       drop_count;

  modport master (
    output frame_valid, frame_data, out_ready,
    input  frame_ready, out_valid, out_data, out_index, out_last, overflow, drop_count
  );

  modport slave (
    input  frame_valid, frame_data, out_ready,
    output frame_ready, out_valid, out_data, out_index, out_last, overflow, drop_count
  );

endinterface

// File: rtl/fft_out_serializer_frame_bank.sv
// One ping-pong bank: parallel frame write, indexed packet read, full flag.
// full_d_o exposes next-cycle occupancy so the top can register frame_ready without a ready->ready path.
module fft_frame_bank
  import fft_out_serializer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  fft_frame_t       wr_data_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output FFT_OUTPUT_PACKET rd_data_o,
  output logic             full_o,
  output logic             full_d_o
);

  fft_frame_t data_q;
  logic       full_q;
  logic       full_d;

  // A write only ever targets an empty bank, so set-over-clear ordering is safe.
  always_comb begin
    full_d = full_q;
    if (clr_i) begin
      full_d = 1'b0;
    end
    if (wr_en_i) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      data_q <= wr_data_i;
    end
  end

  assign rd_data_o = data_q[rd_idx_i];
  assign full_o    = full_q;
  assign full_d_o  = full_d;

endmodule

// File: rtl/fft_out_serializer.sv
// Captures FFT frames into two ping-pong banks and streams one bin per beat; frame to bin 0 in 1 cycle.
// out_ready stalls the stream only; frames offered with no free bank are dropped and counted. Macro: FFT_OUT_REORDER_EN.
module fft_out_serializer
  import fft_out_serializer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  fft_out_serializer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_FFT_POINT - 1);

  FFT_SER_STATE     state_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] k_q;
  logic             rd_bank_q;
  logic             wr_bank_q;
  logic             frame_ready_q;
  logic             frame_ready_d;
  logic             overflow_q;
  logic [7:0]       drop_count_q;

  logic             capture;
  logic             drop;
  logic             beat;
  logic             last_beat;
  logic             rd_bank_filled;
  logic             other_bank_filled;
  logic [1:0]       wr_en;
  logic [1:0]       clr;
  logic [1:0]       full;
  logic [1:0]       full_d;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] freq_idx;
  FFT_OUTPUT_PACKET rd_data [2];

  assign capture   = bus.frame_valid && frame_ready_q;
  assign drop      = bus.frame_valid && !frame_ready_q;
  assign beat      = out_valid_q && bus.out_ready;
  assign last_beat = beat && (k_q == LAST_K);

  assign wr_en[0] = capture && !wr_bank_q;
  assign wr_en[1] = capture &&  wr_bank_q;
  assign clr[0]   = last_beat && !rd_bank_q;
  assign clr[1]   = last_beat &&  rd_bank_q;

  // Counting a same-cycle capture lets bin 0 appear one cycle after capture and keeps back-to-back frames bubble-free.
  assign rd_bank_filled    = full[rd_bank_q]  || wr_en[rd_bank_q];
  assign other_bank_filled = full[~rd_bank_q] || wr_en[~rd_bank_q];

`ifdef FFT_OUT_REORDER_EN
  assign rd_idx   = bitrev(k_q);
  assign freq_idx = k_q;
`else
  assign rd_idx   = k_q;
  assign freq_idx = bitrev(k_q);
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank u_bank (
      .clock     (clock),
      .reset     (reset),
      .wr_en_i   (wr_en[b]),
      .wr_data_i (bus.frame_data),
      .clr_i     (clr[b]),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data[b]),
      .full_o    (full[b]),
      .full_d_o  (full_d[b])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      k_q         <= '0;
      rd_bank_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_bank_filled) begin
            state_q     <= STREAM;
            out_valid_q <= 1'b1;
            k_q         <= '0;
          end
        end
        STREAM: begin
          if (beat) begin
            k_q <= k_q + IDX_W'(1);
            if (last_beat) begin
              rd_bank_q <= ~rd_bank_q;
              if (!other_bank_filled) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_ready_d = ~(full_d[0] & full_d[1]);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b1;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      frame_ready_q <= frame_ready_d;
      if (capture) begin
        wr_bank_q <= ~wr_bank_q;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_q <= drop_count_q + 8'd1;
        end
      end
    end
  end

  assign bus.frame_ready = frame_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_valid_q ? rd_data[rd_bank_q] : '0;
  assign bus.out_index   = freq_idx;
  assign bus.out_last    = out_valid_q && (k_q == LAST_K);
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_count_q;

endmodule
